// File: rtl/fifo_pkg.sv
// Shared definitions for the FIFO slice: read-mode selectors and occupancy width helper.
package fifo_pkg;

  localparam int FIFO_MODE_STD  = 0;
  localparam int FIFO_MODE_FWFT = 1;

  // The occupancy counter needs one extra bit so a completely full FIFO is representable.
  function automatic int count_width(input int log2_depth);
    return log2_depth + 1;
  endfunction

endpackage

// File: rtl/fifo_ram.sv
// Simple dual-port storage: synchronous write port, asynchronous read port.
module fifo_ram #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 3
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/param_fifo.sv
// Parameterised synchronous FIFO with selectable registered or first-word-fall-through read,
// occupancy count, threshold flags and sticky overflow/underflow indicators.
module param_fifo
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int LOG2_DEPTH = 3,
  parameter int FWFT       = FIFO_MODE_STD,
  parameter int AF_TH      = (2 ** LOG2_DEPTH) - 1,
  parameter int AE_TH      = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clear,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  rd_valid,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [LOG2_DEPTH:0]   count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int DEPTH = 2 ** LOG2_DEPTH;
  localparam int CNT_W = count_width(LOG2_DEPTH);
  localparam logic [CNT_W-1:0] DEPTH_LVL = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] AF_LVL    = CNT_W'(AF_TH);
  localparam logic [CNT_W-1:0] AE_LVL    = CNT_W'(AE_TH);

  if (LOG2_DEPTH < 1 || AE_TH >= AF_TH || AF_TH > DEPTH) begin : g_param_check
    $error("param_fifo: illegal parameters (need LOG2_DEPTH >= 1 and AE_TH < AF_TH <= DEPTH)");
  end

  logic [LOG2_DEPTH-1:0] wr_ptr;
  logic [LOG2_DEPTH-1:0] rd_ptr;
  logic [CNT_W-1:0]      count_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic                  valid_q;
  logic [DATA_WIDTH-1:0] ram_rd_data;
  logic                  wr_ok;
  logic                  rd_ok;
  logic                  ram_we;

  assign full         = (count_q == DEPTH_LVL);
  assign empty        = (count_q == '0);
  assign almost_full  = (count_q >= AF_LVL);
  assign almost_empty = (count_q <= AE_LVL);
  assign count        = count_q;

  assign wr_ok  = wr_en && !full;
  assign rd_ok  = rd_en && !empty;
  // Reset and clear both suppress the write so a flush never touches storage.
  assign ram_we = wr_ok && !reset && !clear;

  fifo_ram #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(LOG2_DEPTH)
  ) u_ram (
    .clk    (clk),
    .wr_en  (ram_we),
    .wr_addr(wr_ptr),
    .wr_data(data_in),
    .rd_addr(rd_ptr),
    .rd_data(ram_rd_data)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count_q   <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (clear) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count_q   <= '0;
      valid_q   <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_ok) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (rd_ok) begin
        rd_ptr <= rd_ptr + 1'b1;
        data_q <= ram_rd_data;
      end
      case ({wr_ok, rd_ok})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
      valid_q <= rd_ok;
      if (wr_en && full) begin
        overflow <= 1'b1;
      end
      if (rd_en && empty) begin
        underflow <= 1'b1;
      end
    end
  end

  // In fall-through mode the head word is shown directly; an empty FIFO presents zero.
  assign data_out = (FWFT == FIFO_MODE_FWFT) ? (empty ? '0 : ram_rd_data) : data_q;
  assign rd_valid = (FWFT == FIFO_MODE_FWFT) ? !empty : valid_q;

endmodule

// File: tb/tb_param_fifo.sv
// Scoreboard bench for param_fifo: one registered-read and one fall-through instance,
// driven with directed vectors whose expected read data is queued at issue time.
module tb_param_fifo;

  logic       clk = 1'b0;
  logic       reset_s = 1'b1, clear_s = 1'b0, wr_en_s = 1'b0, rd_en_s = 1'b0;
  logic [7:0] data_in_s = '0;
  logic [7:0] data_out_s;
  logic       rd_valid_s, full_s, empty_s, almost_full_s, almost_empty_s, overflow_s, underflow_s;
  logic [3:0] count_s;

  logic       reset_f = 1'b1, clear_f = 1'b0, wr_en_f = 1'b0, rd_en_f = 1'b0;
  logic [7:0] data_in_f = '0;
  logic [7:0] data_out_f;
  logic       rd_valid_f, full_f, empty_f, almost_full_f, almost_empty_f, overflow_f, underflow_f;
  logic [3:0] count_f;

  logic [7:0] exp_s[$];
  logic [7:0] exp_f[$];
  int n_compared = 0;
  int n_mismatched = 0;

  always #5 clk = ~clk;

  param_fifo #(.DATA_WIDTH(8), .LOG2_DEPTH(3), .FWFT(0)) dut_std (
    .clk(clk), .reset(reset_s), .clear(clear_s), .wr_en(wr_en_s), .data_in(data_in_s),
    .rd_en(rd_en_s), .data_out(data_out_s), .rd_valid(rd_valid_s), .full(full_s),
    .empty(empty_s), .almost_full(almost_full_s), .almost_empty(almost_empty_s),
    .count(count_s), .overflow(overflow_s), .underflow(underflow_s)
  );

  param_fifo #(.DATA_WIDTH(8), .LOG2_DEPTH(3), .FWFT(1)) dut_fwft (
    .clk(clk), .reset(reset_f), .clear(clear_f), .wr_en(wr_en_f), .data_in(data_in_f),
    .rd_en(rd_en_f), .data_out(data_out_f), .rd_valid(rd_valid_f), .full(full_f),
    .empty(empty_f), .almost_full(almost_full_f), .almost_empty(almost_empty_f),
    .count(count_f), .overflow(overflow_f), .underflow(underflow_f)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_compared++;
    if (actual !== expected) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  // Drives the registered-read instance for one clock, returning just after the edge.
  task automatic applyStimulus(input logic wr, input logic [7:0] d, input logic rd,
                               input logic clr, input logic rst);
    wr_en_s = wr; data_in_s = d; rd_en_s = rd; clear_s = clr; reset_s = rst;
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulusFwft(input logic wr, input logic [7:0] d, input logic rd, input logic rst);
    wr_en_f = wr; data_in_f = d; rd_en_f = rd; reset_f = rst;
    @(posedge clk);
    #1;
  endtask

  // Monitor: pops the expected word whenever a DUT presents a read result.
  always @(negedge clk) begin
    if (rd_valid_s === 1'b1) begin
      if (exp_s.size() == 0) begin
        n_compared++;
        n_mismatched++;
        $display("[TB] FAIL std_unexpected_read: got %0h, expected no read", data_out_s);
      end else begin
        checkOutput("std_data_out", data_out_s, exp_s.pop_front());
      end
    end
    if (rd_en_f === 1'b1 && rd_valid_f === 1'b1) begin
      if (exp_f.size() == 0) begin
        n_compared++;
        n_mismatched++;
        $display("[TB] FAIL fwft_unexpected_pop: got %0h, expected no pop", data_out_f);
      end else begin
        checkOutput("fwft_data_out", data_out_f, exp_f.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    applyStimulus(0, 8'h00, 0, 0, 1);
    applyStimulus(0, 8'h00, 0, 0, 1);
    checkOutput("rst_count", count_s, 0);
    checkOutput("rst_empty", empty_s, 1);
    checkOutput("rst_full", full_s, 0);
    checkOutput("rst_almost_empty", almost_empty_s, 1);
    checkOutput("rst_data_out", data_out_s, 8'h00);
    checkOutput("rst_rd_valid", rd_valid_s, 0);
    checkOutput("rst_flags", {overflow_s, underflow_s}, 2'b00);

    // Fill with 0x11..0x18 while watching the threshold flags, then drain in order.
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1, 8'h11 + 8'(i), 0, 0, 0);
      if (i == 0) checkOutput("ae_at_1", almost_empty_s, 1);
      if (i == 1) checkOutput("ae_at_2", almost_empty_s, 0);
      if (i == 5) checkOutput("af_at_6", almost_full_s, 0);
      if (i == 6) checkOutput("af_at_7", almost_full_s, 1);
    end
    checkOutput("fill_full", full_s, 1);
    checkOutput("fill_count", count_s, 8);
    for (int i = 0; i < 8; i++) begin
      exp_s.push_back(8'h11 + 8'(i));
      applyStimulus(0, 8'h00, 1, 0, 0);
    end
    applyStimulus(0, 8'h00, 0, 0, 0);
    checkOutput("drain_empty", empty_s, 1);
    checkOutput("drain_rd_valid", rd_valid_s, 0);

    // Overflow: ninth write rejected, sticky flag, stored data untouched.
    for (int i = 0; i < 8; i++) applyStimulus(1, 8'h11 + 8'(i), 0, 0, 0);
    applyStimulus(1, 8'hAA, 0, 0, 0);
    checkOutput("ovf_count", count_s, 8);
    checkOutput("ovf_flag", overflow_s, 1);
    for (int i = 0; i < 8; i++) begin
      exp_s.push_back(8'h11 + 8'(i));
      applyStimulus(0, 8'h00, 1, 0, 0);
    end
    applyStimulus(0, 8'h00, 0, 0, 0);
    checkOutput("ovf_sticky", overflow_s, 1);
    applyStimulus(0, 8'h00, 0, 1, 0);
    checkOutput("clear_ovf", overflow_s, 0);

    // Wrap: pointers run past the last slot.
    for (int i = 0; i < 6; i++) applyStimulus(1, 8'h01 + 8'(i), 0, 0, 0);
    for (int i = 0; i < 6; i++) begin
      exp_s.push_back(8'h01 + 8'(i));
      applyStimulus(0, 8'h00, 1, 0, 0);
    end
    for (int i = 0; i < 6; i++) applyStimulus(1, 8'h21 + 8'(i), 0, 0, 0);
    for (int i = 0; i < 6; i++) begin
      exp_s.push_back(8'h21 + 8'(i));
      applyStimulus(0, 8'h00, 1, 0, 0);
    end
    applyStimulus(0, 8'h00, 0, 0, 0);
    checkOutput("wrap_empty", empty_s, 1);

    // Simultaneous read/write at count 4, full and empty.
    for (int i = 0; i < 4; i++) applyStimulus(1, 8'h31 + 8'(i), 0, 0, 0);
    for (int i = 0; i < 10; i++) begin
      exp_s.push_back(8'h31 + 8'(i));
      applyStimulus(1, 8'h35 + 8'(i), 1, 0, 0);
    end
    checkOutput("rw_count4", count_s, 4);
    for (int i = 0; i < 4; i++) begin
      exp_s.push_back(8'h3B + 8'(i));
      applyStimulus(0, 8'h00, 1, 0, 0);
    end
    for (int i = 0; i < 8; i++) applyStimulus(1, 8'h41 + 8'(i), 0, 0, 0);
    exp_s.push_back(8'h41);
    applyStimulus(1, 8'h99, 1, 0, 0);
    checkOutput("rw_full_count", count_s, 7);
    checkOutput("rw_full_ovf", overflow_s, 1);
    for (int i = 0; i < 7; i++) begin
      exp_s.push_back(8'h42 + 8'(i));
      applyStimulus(0, 8'h00, 1, 0, 0);
    end
    applyStimulus(0, 8'h00, 0, 0, 0);
    applyStimulus(1, 8'h77, 1, 0, 0);
    checkOutput("rw_empty_count", count_s, 1);
    checkOutput("rw_empty_unf", underflow_s, 1);
    checkOutput("rw_empty_rd_valid", rd_valid_s, 0);
    checkOutput("rw_empty_data_hold", data_out_s, 8'h48);
    exp_s.push_back(8'h77);
    applyStimulus(0, 8'h00, 1, 0, 0);
    applyStimulus(0, 8'h00, 0, 0, 0);

    // Clear with pending write, then reset together with clear, then reuse.
    for (int i = 0; i < 5; i++) applyStimulus(1, 8'h81 + 8'(i), 0, 0, 0);
    checkOutput("pre_clear_count", count_s, 5);
    applyStimulus(1, 8'hEE, 0, 1, 0);
    checkOutput("clear_count", count_s, 0);
    checkOutput("clear_empty", empty_s, 1);
    checkOutput("clear_flags", {overflow_s, underflow_s}, 2'b00);
    checkOutput("clear_data_hold", data_out_s, 8'h77);
    for (int i = 0; i < 3; i++) applyStimulus(1, 8'h91 + 8'(i), 0, 0, 0);
    applyStimulus(0, 8'h00, 0, 1, 1);
    checkOutput("rst_clear_data", data_out_s, 8'h00);
    checkOutput("rst_clear_count", count_s, 0);
    applyStimulus(1, 8'h5A, 0, 0, 0);
    exp_s.push_back(8'h5A);
    applyStimulus(0, 8'h00, 1, 0, 0);
    applyStimulus(0, 8'h00, 0, 0, 0);
    checkOutput("post_rst_empty", empty_s, 1);

    // Fall-through instance.
    applyStimulusFwft(0, 8'h00, 0, 1);
    applyStimulusFwft(0, 8'h00, 0, 0);
    checkOutput("fwft_rst_data", data_out_f, 8'h00);
    checkOutput("fwft_rst_valid", rd_valid_f, 0);
    applyStimulusFwft(1, 8'h55, 0, 0);
    checkOutput("fwft_head", data_out_f, 8'h55);
    checkOutput("fwft_valid", rd_valid_f, 1);
    applyStimulusFwft(0, 8'h00, 0, 0);
    checkOutput("fwft_head_hold", data_out_f, 8'h55);
    exp_f.push_back(8'h55);
    applyStimulusFwft(0, 8'h00, 1, 0);
    checkOutput("fwft_pop_empty", empty_f, 1);
    checkOutput("fwft_pop_valid", rd_valid_f, 0);
    for (int i = 0; i < 3; i++) applyStimulusFwft(1, 8'h61 + 8'(i), 0, 0);
    checkOutput("fwft_head2", data_out_f, 8'h61);
    for (int i = 0; i < 3; i++) begin
      exp_f.push_back(8'h61 + 8'(i));
      applyStimulusFwft(0, 8'h00, 1, 0);
    end
    applyStimulusFwft(0, 8'h00, 0, 0);
    checkOutput("fwft_end_empty", empty_f, 1);

    applyStimulus(0, 8'h00, 0, 0, 0);
    checkOutput("std_queue_drained", exp_s.size(), 0);
    checkOutput("fwft_queue_drained", exp_f.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
